// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - two-port round-robin arbiter driving a 4-bit HD44780-style LCD write cycle
`timescale 1ns/1ps
module lcd_write_arbiter #(
    parameter int T_SU  = 2,
    parameter int T_E   = 12,
    parameter int T_HD  = 2,
    parameter int T_GAP = 50,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       valid0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       valid1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [3:0] dataout,
    output logic [2:0] control,
    output logic       busy,
    output logic       done
);
    typedef enum logic [3:0] {IDLE, SU_H, E_H, HD_H, GAP, SU_L, E_L, HD_L, WAIT} state_t;

    localparam int CW = 17;
    localparam logic [CW-1:0] LD_SU  = CW'(T_SU - 1);
    localparam logic [CW-1:0] LD_E   = CW'(T_E - 1);
    localparam logic [CW-1:0] LD_HD  = CW'(T_HD - 1);
    localparam logic [CW-1:0] LD_GAP = CW'(T_GAP - 1);
    localparam logic [CW-1:0] LD_CMD = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLR = CW'(T_CLR - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rs_q;
    logic [7:0]    byte_q;
    logic          last_q;
    logic          pick1;
    logic          cnt_zero;
    logic          slow_cmd;

    // With both requesting, the port that did not win last time gets the grant.
    assign pick1    = (valid0 && valid1) ? ~last_q : ~valid0;
    assign cnt_zero = (cnt_q == '0);
    assign slow_cmd = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            byte_q  <= 8'h00;
            last_q  <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataout <= 4'h0;
            control <= 3'b000;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && (valid0 || valid1)) begin
                        state_q <= SU_H;
                        cnt_q   <= LD_SU;
                        last_q  <= pick1;
                        rs_q    <= pick1 ? rs1 : rs0;
                        byte_q  <= pick1 ? data1 : data0;
                        ack0    <= ~pick1;
                        ack1    <= pick1;
                        busy    <= 1'b1;
                        dataout <= pick1 ? data1[7:4] : data0[7:4];
                        control <= {1'b0, pick1 ? rs1 : rs0, 1'b0};
                    end
                end
                SU_H, SU_L: begin
                    if (cnt_zero) begin
                        state_q <= (state_q == SU_H) ? E_H : E_L;
                        cnt_q   <= LD_E;
                        control <= {1'b1, rs_q, 1'b0};
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                E_H, E_L: begin
                    if (cnt_zero) begin
                        state_q <= (state_q == E_H) ? HD_H : HD_L;
                        cnt_q   <= LD_HD;
                        control <= {1'b0, rs_q, 1'b0};
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                HD_H: begin
                    if (cnt_zero) begin
                        state_q <= GAP;
                        cnt_q   <= LD_GAP;
                        control <= 3'b000;
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state_q <= SU_L;
                        cnt_q   <= LD_SU;
                        dataout <= byte_q[3:0];
                        control <= {1'b0, rs_q, 1'b0};
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                HD_L: begin
                    if (cnt_zero) begin
                        state_q <= WAIT;
                        cnt_q   <= slow_cmd ? LD_CLR : LD_CMD;
                        control <= 3'b000;
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy    <= 1'b0;
                    control <= 3'b000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - directed bench for lcd_write_arbiter
`timescale 1ns/1ps
module tb_lcd_write_arbiter;
    localparam int TE = 12;
    localparam int B1 = 2;
    localparam int B2 = B1 + TE;
    localparam int B3 = B2 + 2;
    localparam int B4 = B3 + 50;
    localparam int B5 = B4 + 2;
    localparam int B6 = B5 + TE;
    localparam int B7 = B6 + 2;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic       valid0, rs0, ack0, valid1, rs1, ack1;
    logic [7:0] data0, data1;
    logic [3:0] dataout;
    logic [2:0] control;
    logic       busy, done;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int both_cnt = 0;

    lcd_write_arbiter dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .valid0(valid0), .rs0(rs0), .data0(data0), .ack0(ack0),
        .valid1(valid1), .rs1(rs1), .data1(data1), .ack1(ack1),
        .dataout(dataout), .control(control), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ack0 === 1'b1 && ack1 === 1'b1) both_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_ctl(input int k, input logic rs);
        if (k < B1)      return {1'b0, rs, 1'b0};
        else if (k < B2) return {1'b1, rs, 1'b0};
        else if (k < B3) return {1'b0, rs, 1'b0};
        else if (k < B4) return 3'b000;
        else if (k < B5) return {1'b0, rs, 1'b0};
        else if (k < B6) return {1'b1, rs, 1'b0};
        else if (k < B7) return {1'b0, rs, 1'b0};
        else             return 3'b000;
    endfunction

    task automatic wait_ack(output int port);
        port = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                port = (ack1 === 1'b1) ? 1 : 0;
                break;
            end
        end
    endtask

    // k counts negedges after the ack became visible (k = 0 is the first SU_H cycle).
    task automatic xfer(input string tag, input logic rs, input logic [3:0] hi, input logic [3:0] lo,
                        input int wait_c, input int k0, input int kend);
        int lat, bad, eh, el;
        logic [3:0] dh, dl;
        logic ers;
        lat = B7 + wait_c;
        bad = 0; eh = 0; el = 0;
        dh = ~hi; dl = ~lo; ers = ~rs;
        for (int k = k0; k <= kend; k++) begin
            if (k != k0) @(negedge clk);
            if (k < lat) begin
                if (control !== exp_ctl(k, rs) || dataout !== ((k < B4) ? hi : lo) ||
                    busy !== 1'b1 || done !== 1'b0 || (k > 0 && (ack0 | ack1) !== 1'b0))
                    bad++;
                if (control[2] === 1'b1) begin
                    if (k < B4) begin eh++; dh = dataout; ers = control[1]; end
                    else begin el++; dl = dataout; end
                end
            end else begin
                chk({tag, "_done_latency"}, {30'd0, done, busy}, 32'h2);
            end
        end
        chk({tag, "_wave"}, bad, 0);
        chk({tag, "_e_high_cycles"}, eh, TE);
        chk({tag, "_hi_nibble"}, dh, hi);
        chk({tag, "_rs_in_e"}, ers, rs);
        if (kend >= B6) begin
            chk({tag, "_e_low_cycles"}, el, TE);
            chk({tag, "_lo_nibble"}, dl, lo);
        end
    endtask

    initial begin
        int p, bad;
        rst_n = 1'b0; en = 1'b0;
        valid0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
        valid1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
        @(negedge clk);
        chk("rst_control", control, 3'b000);
        chk("rst_dataout", dataout, 4'h0);
        chk("rst_flags", {ack0, ack1, busy, done}, 4'b0000);
        rst_n = 1'b1;

        en = 1'b1; valid0 = 1'b1; rs0 = 1'b1; data0 = 8'h44;
        wait_ack(p);
        chk("single_ack_port", p, 0);
        valid0 = 1'b0;
        xfer("single", 1'b1, 4'h4, 4'h4, 2000, 0, B7 + 2000);

        valid1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
        wait_ack(p);
        chk("clear_ack_port", p, 1);
        valid1 = 1'b0;
        xfer("clear", 1'b0, 4'h0, 4'h1, 82000, 0, B7 + 82000);

        en = 1'b0; valid1 = 1'b1; rs1 = 1'b1; data1 = 8'h33;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({ack0, ack1, busy} !== 3'b000) bad++;
        end
        chk("en_blocks_grant", bad, 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_rise_ack1", {ack0, ack1}, 2'b01);
        valid1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        valid0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        valid1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
        for (int i = 0; i < 3; i++) begin
            wait_ack(p);
            chk($sformatf("rr_order_%0d", i), p, (i == 1) ? 1 : 0);
            if (i < 2) begin
                xfer($sformatf("rr%0d", i), 1'b1, 4'h4, (i == 1) ? 4'h2 : 4'h1, 2000, 0, B7 + 2000);
            end else begin
                valid0 = 1'b0; valid1 = 1'b0;
                xfer("rr2", 1'b1, 4'h4, 4'h1, 2000, 0, B5 + 2);
            end
        end

        rst_n = 1'b0;
        #1;
        chk("abort_control", control, 3'b000);
        chk("abort_dataout", dataout, 4'h0);
        chk("abort_busy", busy, 1'b0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if ({done, ack0, ack1, busy, control} !== 7'd0) bad++;
        end
        chk("abort_quiet", bad, 0);
        rst_n = 1'b1;
        valid0 = 1'b1; rs0 = 1'b1; data0 = 8'h65;
        valid1 = 1'b1; rs1 = 1'b0; data1 = 8'h02;
        wait_ack(p);
        chk("rst_rr_port0", p, 0);
        valid0 = 1'b0; valid1 = 1'b0;
        @(negedge clk);
        data0 = 8'h6E; rs0 = 1'b0;
        xfer("latched", 1'b1, 4'h6, 4'h5, 2000, 1, B7 - 1);

        chk("never_both_acks", both_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
